// File: rtl/ysyx_23060136_ifu_fetch_if.sv
// Instruction-memory port of the fetch stage: one request channel, one response channel.
// The IFU is the master; the memory (or its model) is the slave.
interface ysyx_23060136_ifu_fetch_if #(
  parameter int BITS_W = 64,
  parameter int INST_W = 32
);
  logic              IFU_o_mem_req_valid;
  logic [BITS_W-1:0] IFU_o_mem_req_addr;
  logic              IFU_i_mem_req_ready;
  logic              IFU_i_mem_resp_valid;
  logic [INST_W-1:0] IFU_i_mem_resp_inst;
  logic              IFU_i_mem_resp_err;

  modport master (
    output IFU_o_mem_req_valid,
    output IFU_o_mem_req_addr,
    input  IFU_i_mem_req_ready,
    input  IFU_i_mem_resp_valid,
    input  IFU_i_mem_resp_inst,
    input  IFU_i_mem_resp_err
  );

  modport slave (
    input  IFU_o_mem_req_valid,
    input  IFU_o_mem_req_addr,
    output IFU_i_mem_req_ready,
    output IFU_i_mem_resp_valid,
    output IFU_i_mem_resp_inst,
    output IFU_i_mem_resp_err
  );
endinterface

// File: rtl/ysyx_23060136_ifu_fetch.sv
// Fetch stage: holds the fetch PC, keeps one memory request in flight and buffers one
// response for the IDU. Redirects discard in-flight fetches; an access fault halts fetch.
module ysyx_23060136_ifu_fetch #(
   parameter int                BITS_W   = 64,
   parameter int                INST_W   = 32,
   parameter logic [BITS_W-1:0] RESET_PC = BITS_W'(64'h8000_0000)
) (
   input  logic                             clk,
   input  logic                             rst,
   ysyx_23060136_ifu_fetch_if.master        mem,
   input  logic                             IFU_i_redirect,
   input  logic [BITS_W-1:0]                IFU_i_redirect_pc,
   output logic                             IFU_o_valid,
   input  logic                             IFU_i_ready,
   output logic [BITS_W-1:0]                IFU_o_pc,
   output logic [INST_W-1:0]                IFU_o_inst,
   output logic                             IFU_o_commit,
   output logic                             IFU_o_fault
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DROP,
      S_HALT
   } state_t;

   state_t            state, state_nxt;
   logic [BITS_W-1:0] fetch_pc;
   logic              req_valid;
   logic              req_fire;
   logic              resp;
   logic              resp_err;
   logic              take;
   logic              drain;

   // A request is only issued when the buffer is free by the time the response lands.
   assign req_valid = (state == S_REQ) && (!IFU_o_valid || IFU_i_ready);
   assign req_fire  = req_valid && mem.IFU_i_mem_req_ready;
   assign resp      = mem.IFU_i_mem_resp_valid;
   assign resp_err  = mem.IFU_i_mem_resp_err;
   assign take      = (state == S_WAIT) && resp && !IFU_i_redirect;
   assign drain     = IFU_o_valid && IFU_i_ready;

   assign mem.IFU_o_mem_req_valid = req_valid;
   assign mem.IFU_o_mem_req_addr  = fetch_pc;

   // NOTE: every variable assigned here gets a default first, so no path infers a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  state_nxt = S_REQ;
         S_REQ:   if (req_fire) state_nxt = S_WAIT;
         S_WAIT:  if (resp) state_nxt = resp_err ? S_HALT : S_REQ;
         S_DROP:  if (resp) state_nxt = S_REQ;
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase

      // A request still outstanding after a redirect must have its response swallowed.
      if (IFU_i_redirect) begin
         unique case (state)
            S_REQ:   state_nxt = req_fire ? S_DROP : S_REQ;
            S_WAIT,
            S_DROP:  state_nxt = resp ? S_REQ : S_DROP;
            default: state_nxt = S_REQ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      // NOTE: every register here is a control or datapath flop with a defined reset value;
      // there is no storage array, so nothing is left unreset.
      if (rst) begin
         state        <= S_IDLE;
         fetch_pc     <= RESET_PC;
         IFU_o_valid  <= 1'b0;
         IFU_o_pc     <= '0;
         IFU_o_inst   <= '0;
         IFU_o_commit <= 1'b0;
         IFU_o_fault  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (IFU_i_redirect) begin
            fetch_pc     <= IFU_i_redirect_pc;
            IFU_o_valid  <= 1'b0;
            IFU_o_commit <= 1'b0;
            IFU_o_fault  <= 1'b0;
         end else if (take) begin
            IFU_o_valid  <= 1'b1;
            IFU_o_pc     <= fetch_pc;
            IFU_o_inst   <= resp_err ? '0 : mem.IFU_i_mem_resp_inst;
            IFU_o_commit <= !resp_err;
            IFU_o_fault  <= resp_err;
            if (!resp_err) fetch_pc <= fetch_pc + BITS_W'(4);
         end else if (drain) begin
            IFU_o_valid  <= 1'b0;
            IFU_o_commit <= 1'b0;
            IFU_o_fault  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060136_ifu_fetch.sv
// Randomized bench for the fetch stage: a memory model with variable latency, a transaction
// scoreboard of expected IDU entries, and a request-eligibility model checked every cycle.
module tb_ysyx_23060136_ifu_fetch;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [63:0] o_pc;
  logic [31:0] o_inst;
  logic        o_commit;
  logic        o_fault;

  ysyx_23060136_ifu_fetch_if #(.BITS_W(64), .INST_W(32)) mem ();

  ysyx_23060136_ifu_fetch #(.BITS_W(64), .INST_W(32), .RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem               (mem.master),
    .IFU_i_redirect    (redirect),
    .IFU_i_redirect_pc (redirect_pc),
    .IFU_o_valid       (o_valid),
    .IFU_i_ready       (i_ready),
    .IFU_o_pc          (o_pc),
    .IFU_o_inst        (o_inst),
    .IFU_o_commit      (o_commit),
    .IFU_o_fault       (o_fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference state: where fetch should be, what the IDU should see next.
  entry_t      exp_q[$];
  logic [63:0] exp_fetch;
  bit          halted, outstanding, stale, first;
  int          pend_cnt;
  logic [63:0] pend_addr;

  // Knobs (percentages) and observation counters for directed phases.
  int          k_mem_rdy, k_idu_rdy, k_redir, k_err, k_dly;
  logic [63:0] err_addr;
  bit          force_redir;
  logic [63:0] force_pc;
  int          cyc, n_hs, first_hs, first_ov;
  bit          saw_zero, saw_fault;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    return (lo * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_fetch   = RESET_PC;
    halted      = 0;
    outstanding = 0;
    stale       = 0;
    first       = 1;
    pend_cnt    = 0;
    pend_addr   = '0;
    cyc         = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    i_ready = 1'b0;
    mem.IFU_i_mem_req_ready  = 1'b0;
    mem.IFU_i_mem_resp_valid = 1'b0;
    mem.IFU_i_mem_resp_inst  = '0;
    mem.IFU_i_mem_resp_err   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_pc", o_pc, 64'd0);
    check("rst_o_inst", 64'(o_inst), 64'd0);
    check("rst_o_commit", 64'(o_commit), 64'd0);
    check("rst_o_fault", 64'(o_fault), 64'd0);
    check("rst_req_valid", 64'(mem.IFU_o_mem_req_valid), 64'd0);
    check("rst_req_addr", mem.IFU_o_mem_req_addr, RESET_PC);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic step();
    bit          rsp, err, hs, exp_req;
    logic [63:0] tgt;
    entry_t      e;

    mem.IFU_i_mem_req_ready = ($urandom_range(99) < k_mem_rdy);
    i_ready = ($urandom_range(99) < k_idu_rdy);
    rsp = outstanding && (pend_cnt == 0);
    err = rsp && ((pend_addr == err_addr) || ($urandom_range(99) < k_err));
    mem.IFU_i_mem_resp_valid = rsp;
    mem.IFU_i_mem_resp_inst  = rsp ? inst_of(pend_addr) : $urandom;
    mem.IFU_i_mem_resp_err   = err;
    tgt = ($urandom_range(7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                   : RESET_PC + 64'($urandom_range(255)) * 4;
    redirect    = force_redir || ($urandom_range(99) < k_redir);
    redirect_pc = force_redir ? force_pc : tgt;
    force_redir = 0;
    #1;

    exp_req = !first && !halted && !outstanding && (exp_q.size() == 0 || i_ready);
    check("req_valid", 64'(mem.IFU_o_mem_req_valid), 64'(exp_req));
    check("o_valid", 64'(o_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      if (first_ov < 0) first_ov = cyc;
      check("o_pc", o_pc, exp_q[0].pc);
      check("o_inst", 64'(o_inst), 64'(exp_q[0].inst));
      check("o_fault", 64'(o_fault), 64'(exp_q[0].fault));
      check("o_commit", 64'(o_commit), 64'(!exp_q[0].fault));
    end
    hs = exp_req && mem.IFU_i_mem_req_ready;
    if (hs) begin
      check("req_addr", mem.IFU_o_mem_req_addr, exp_fetch);
      n_hs++;
      if (first_hs < 0) first_hs = cyc;
      if (mem.IFU_o_mem_req_addr == 64'd0) saw_zero = 1;
    end

    if (outstanding && !rsp) pend_cnt--;
    if (redirect) begin
      exp_q.delete();
      exp_fetch = redirect_pc;
      halted = 0;
      if (rsp) outstanding = 0;
      if (outstanding) stale = 1;
    end else begin
      if (exp_q.size() != 0 && i_ready) begin
        if (exp_q[0].fault && exp_q[0].pc == 64'h8000_0008) saw_fault = 1;
        void'(exp_q.pop_front());
      end
      if (rsp) begin
        outstanding = 0;
        if (!stale) begin
          e.pc    = pend_addr;
          e.inst  = err ? 32'd0 : inst_of(pend_addr);
          e.fault = err;
          exp_q.push_back(e);
          if (err) halted = 1;
          else exp_fetch = exp_fetch + 64'd4;
        end
        stale = 0;
      end
    end
    if (hs) begin
      outstanding = 1;
      stale       = redirect;
      pend_addr   = mem.IFU_o_mem_req_addr;
      pend_cnt    = $urandom_range(k_dly);
    end
    first = 0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_knobs(input int mr, input int ir, input int rd, input int er, input int dl);
    k_mem_rdy = mr;
    k_idu_rdy = ir;
    k_redir   = rd;
    k_err     = er;
    k_dly     = dl;
  endtask

  initial begin
    force_redir = 0;
    err_addr    = 64'h1;
    saw_zero    = 0;
    saw_fault   = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Zero-wait memory, IDU always ready: first request one cycle after reset, then one per 2.
    set_knobs(100, 100, 0, 0, 0);
    n_hs = 0;
    first_hs = -1;
    first_ov = -1;
    repeat (21) step();
    check("first_req_cycle", 64'(first_hs), 64'd1);
    check("first_out_cycle", 64'(first_ov), 64'd3);
    check("req_count_21cyc", 64'(n_hs), 64'd10);

    // IDU stalls with a buffered entry: no request, entry held.
    set_knobs(100, 0, 0, 0, 0);
    repeat (6) step();
    set_knobs(100, 100, 0, 0, 0);
    repeat (6) step();

    // Stale response several cycles after a redirect raised during a slow fetch.
    set_knobs(100, 100, 0, 0, 3);
    repeat (3) step();
    force_redir = 1;
    force_pc = 64'h8000_0100;
    repeat (20) step();

    // Wrap-around at the top of the address space.
    set_knobs(100, 100, 0, 0, 0);
    force_redir = 1;
    force_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    repeat (10) step();
    check("wrap_to_zero", 64'(saw_zero), 64'd1);

    // Fault at 0x8000_0008 halts fetch; a redirect resumes it.
    err_addr = 64'h8000_0008;
    force_redir = 1;
    force_pc = RESET_PC;
    repeat (20) step();
    check("fault_seen", 64'(saw_fault), 64'd1);
    err_addr = 64'h1;
    force_redir = 1;
    force_pc = RESET_PC;
    repeat (10) step();

    // Random traffic, a reset in the middle, more random traffic.
    set_knobs(70, 70, 5, 3, 3);
    repeat (3000) step();
    do_reset();
    set_knobs(60, 80, 8, 5, 2);
    repeat (1500) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
